// File: rtl/dp_pkg.sv
// Shared encodings for the multi-cycle datapath.
// Opcodes, ALU functions, FSM states and sign-extension sizing.
package dp_pkg;

  typedef enum logic [1:0] {
    OP_R    = 2'b00,
    OP_ADDI = 2'b01,
    OP_LW   = 2'b10,
    OP_SW   = 2'b11
  } op_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EX,
    S_MEM,
    S_WB
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int SEXT_W     = 16;

endpackage

// File: rtl/dp_regfile.sv
// Register file: two operand read ports, a debug read port, one write port.
// Asynchronous clear; register 0 is hardwired to zero.
module dp_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_ra,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_rb,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (i_we && i_wa != '0) begin
      regs[i_wa] <= i_wd;
    end
  end

  assign o_rdata_a  = (i_ra == '0) ? '0 : regs[i_ra];
  assign o_rdata_b  = (i_rb == '0) ? '0 : regs[i_rb];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : regs[i_dbg_addr];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RF/ALU/data-memory datapath: IDLE -> RD -> EX -> [MEM] -> WB.
// One instruction per handshake; inputs are latched at acceptance.
module mc_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = 5,
  parameter int IMM_W  = DEF_DATA_W - SEXT_W,
  parameter int DM_AW  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [2:0]        i_alu_ctrl,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [IMM_W-1:0]  i_imm,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  state_e            state;
  op_e               op_q;
  logic [2:0]        ctrl_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] a_q, b_q, simm_q;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [DATA_W-1:0] alu_y, opb;
  logic [2:0]        fn;
  logic [DM_AW-1:0]  maddr;
  logic              we;
  logic [REG_AW-1:0] wa;

  logic [DATA_W-1:0] dmem [2**DM_AW];

  // Register write happens on the edge leaving WB
  assign we = (state == S_WB) && (op_q != OP_SW);
  assign wa = (op_q == OP_R) ? rd_q : rt_q;

  dp_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ra       (rs_q),
    .o_rdata_a  (rs_data),
    .i_rb       (rt_q),
    .o_rdata_b  (rt_data),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data),
    .i_we       (we),
    .i_wa       (wa),
    .i_wd       (o_result)
  );

  always_comb begin
    fn    = (op_q == OP_R) ? ctrl_q : ALU_ADD;
    opb   = (op_q == OP_R) ? b_q : simm_q;
    alu_y = '0;
    unique case (1'b1)
      (fn == ALU_AND): alu_y = a_q & opb;
      (fn == ALU_OR):  alu_y = a_q | opb;
      (fn == ALU_ADD): alu_y = a_q + opb;
      (fn == ALU_SUB): alu_y = a_q - opb;
      (fn == ALU_NOR): alu_y = ~(a_q | opb);
      (fn == ALU_SLT):
        alu_y = {{(DATA_W-1){1'b0}},
                 ($signed(a_q) < $signed(opb))};
      default: alu_y = '0;
    endcase
  end

  // Byte address from the ALU; only the word index is used
  assign maddr = o_result[DM_AW+1:2];

  always_ff @(posedge i_clk) begin
    if (state == S_MEM && op_q == OP_SW)
      dmem[maddr] <= b_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      o_ready  <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b0;
      op_q     <= OP_R;
      ctrl_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      simm_q   <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_valid) begin
            op_q    <= op_e'(i_op);
            ctrl_q  <= i_alu_ctrl;
            rs_q    <= i_rs;
            rt_q    <= i_rt;
            rd_q    <= i_rd;
            imm_q   <= i_imm;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            state   <= S_RD;
          end
        end
        S_RD: begin
          a_q    <= rs_data;
          b_q    <= rt_data;
          simm_q <= {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
          state  <= S_EX;
        end
        S_EX: begin
          o_result <= alu_y;
          o_zero   <= (alu_y == '0);
          if (op_q == OP_LW || op_q == OP_SW) begin
            state <= S_MEM;
          end else begin
            state  <= S_WB;
            o_done <= 1'b1;
          end
        end
        S_MEM: begin
          if (op_q == OP_LW)
            o_result <= dmem[maddr];
          state  <= S_WB;
          o_done <= 1'b1;
        end
        S_WB: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath against an instruction-level model.
// Model tracks registers, memory and expected completion timing.
module tb_mc_datapath;

  logic        clk = 0;
  logic        rst_n = 1;
  logic        valid = 0;
  logic [1:0]  op = 0;
  logic [2:0]  ctrl = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0, dbg = 0;
  logic [15:0] imm = 0;
  logic        ready, busy, done, zero;
  logic [31:0] result, dbg_data;

  always #5 clk = ~clk;

  mc_datapath dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_op       (op),
    .i_alu_ctrl (ctrl),
    .i_rs       (rs),
    .i_rt       (rt),
    .i_rd       (rd),
    .i_imm      (imm),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_zero     (zero),
    .i_dbg_addr (dbg),
    .o_dbg_data (dbg_data)
  );

  logic [31:0] mregs [32];
  logic [31:0] mmem  [256];
  int          vecs = 0;
  int          errs = 0;
  bit          infl = 0;
  int          k = 0;
  int          lat = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] er;
  bit          ez;
  int          wdst;
  logic [31:0] wval;
  bit          st_en;
  logic [7:0]  st_addr;
  logic [31:0] st_data;
  bit          armed = 0;
  bit          ed;
  logic [31:0] last_res;
  logic        last_zero;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(string name, logic got, logic exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Instruction-level semantics evaluated at acceptance
  task automatic model_accept();
    logic [31:0] a, b, s, y;
    a = mregs[rs];
    b = mregs[rt];
    s = {{16{imm[15]}}, imm};
    wdst = 0;
    st_en = 0;
    y = a + s;
    case (op)
      2'b00: begin
        case (ctrl)
          3'b000:  y = a & b;
          3'b001:  y = a | b;
          3'b010:  y = a + b;
          3'b110:  y = a - b;
          3'b111:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'b101:  y = ~(a | b);
          default: y = 32'd0;
        endcase
        er = y; wdst = int'(rd); wval = y; lat = 3;
      end
      2'b01: begin
        er = y; wdst = int'(rt); wval = y; lat = 3;
      end
      2'b10: begin
        er = mmem[y[9:2]]; wdst = int'(rt); wval = er; lat = 4;
      end
      default: begin
        er = y; st_en = 1; st_addr = y[9:2]; st_data = b; lat = 4;
      end
    endcase
    ez = (y == 32'd0);
  endtask

  always @(negedge rst_n) begin
    infl = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      infl = 0;
    end else if (infl) begin
      k++;
      if (k == lat) begin
        if (wdst != 0) mregs[wdst] = wval;
        if (st_en) mmem[st_addr] = st_data;
        infl = 0;
      end
    end else if (valid) begin
      model_accept();
      infl = 1;
      k = 0;
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (!rst_n) begin
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_result", result, 32'd0);
        chk1("rst_zero", zero, 1'b0);
      end else begin
        ed = infl && (k == lat - 1);
        chk1("ready", ready, !infl);
        chk1("busy", busy, infl);
        chk1("done", done, ed);
        if (done) done_cnt++;
        if (ed) begin
          chk("result", result, er);
          chk1("zero", zero, ez);
          last_res = result;
          last_zero = zero;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [2:0] c,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] im,
                       input bit hold);
    int c0;
    @(negedge clk);
    op = o; ctrl = c; rs = s; rt = t; rd = d; imm = im;
    valid = 1;
    c0 = acc_cnt;
    for (int i = 0; i < 20 && acc_cnt == c0; i++) @(negedge clk);
    if (acc_cnt == c0) begin
      vecs++; errs++;
      $display("FAIL accept_timeout: got none expected acceptance");
      valid = 0;
      return;
    end
    op = 2'($urandom); ctrl = 3'($urandom);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom);
    valid = hold;
    for (int i = 0; i < 20 && infl; i++) @(negedge clk);
    valid = 0;
    if (infl) begin
      vecs++; errs++;
      $display("FAIL done_timeout: got busy expected idle");
    end
  endtask

  task automatic dchk(string name, input logic [4:0] a, input logic [31:0] exp);
    dbg = a;
    #1;
    chk(name, dbg_data, exp);
    chk({name, "_model"}, dbg_data, mregs[a]);
  endtask

  initial begin
    int d0, c0;
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int d0, c0;
    #2;
    rst_n = 0;
    armed = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 32; i++) begin
      dbg = 5'(i);
      #1;
      chk("rst_reg", dbg_data, 32'd0);
    end

    issue(2'b01, 3'd0, 5'd0, 5'd1, 5'd0, 16'd5, 0);
    chk("addi_r1", last_res, 32'd5);
    issue(2'b00, 3'b010, 5'd1, 5'd1, 5'd2, 16'd0, 0);
    chk("add_r2", last_res, 32'd10);
    chk1("add_zero", last_zero, 1'b0);
    dchk("dbg_r2", 5'd2, 32'd10);
    issue(2'b01, 3'd0, 5'd0, 5'd3, 5'd0, 16'hFFFD, 0);
    dchk("dbg_r3", 5'd3, 32'hFFFFFFFD);
    issue(2'b00, 3'b111, 5'd3, 5'd1, 5'd4, 16'd0, 0);
    chk("slt_r4", last_res, 32'd1);
    issue(2'b00, 3'b111, 5'd1, 5'd3, 5'd12, 16'd0, 0);
    chk("slt_r12", last_res, 32'd0);
    issue(2'b00, 3'b110, 5'd1, 5'd1, 5'd5, 16'd0, 0);
    chk("sub_r5", last_res, 32'd0);
    chk1("sub_zero", last_zero, 1'b1);
    issue(2'b00, 3'b101, 5'd0, 5'd0, 5'd6, 16'd0, 0);
    chk("nor_r6", last_res, 32'hFFFFFFFF);
    issue(2'b00, 3'b000, 5'd3, 5'd1, 5'd10, 16'd0, 0);
    chk("and_r10", last_res, 32'd5);
    issue(2'b00, 3'b001, 5'd3, 5'd1, 5'd11, 16'd0, 0);
    chk("or_r11", last_res, 32'hFFFFFFFD);
    issue(2'b00, 3'b010, 5'd6, 5'd1, 5'd13, 16'd0, 0);
    chk("add_wrap", last_res, 32'd4);

    issue(2'b11, 3'd0, 5'd0, 5'd2, 5'd0, 16'd8, 0);
    chk("sw_addr", last_res, 32'd8);
    issue(2'b10, 3'd0, 5'd0, 5'd7, 5'd0, 16'd11, 0);
    chk("lw_r7", last_res, 32'd10);
    dchk("dbg_r7", 5'd7, 32'd10);

    d0 = done_cnt;
    c0 = acc_cnt;
    issue(2'b01, 3'd0, 5'd0, 5'd0, 5'd0, 16'd7, 1);
    chk("addi_r0", last_res, 32'd7);
    dchk("dbg_r0", 5'd0, 32'd0);
    chk("one_done", 32'(done_cnt - d0), 32'd1);
    chk("one_accept", 32'(acc_cnt - c0), 32'd1);

    @(negedge clk);
    op = 2'b01; rs = 5'd0; rt = 5'd8; imm = 16'd9;
    valid = 1;
    c0 = acc_cnt;
    for (int i = 0; i < 20 && acc_cnt == c0; i++) @(negedge clk);
    valid = 0;
    chk("abort_accept", 32'(acc_cnt - c0), 32'd1);
    @(posedge clk);
    #2 rst_n = 0;
    @(posedge clk);
    #2 rst_n = 1;
    dchk("abort_r8", 5'd8, 32'd0);
    dchk("abort_r2", 5'd2, 32'd0);
    @(negedge clk);
    chk1("abort_ready", ready, 1'b1);
    issue(2'b01, 3'd0, 5'd0, 5'd9, 5'd0, 16'd4, 0);
    chk("after_rst", last_res, 32'd4);
    dchk("dbg_r9", 5'd9, 32'd4);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised multi-cycle successor to the single-step RF/ALU/data-memory datapath. It accepts one decoded instruction per valid/ready handshake and sequences it through register read, ALU, optional data-memory access and write-back under an internal FSM. It owns its register file and data memory, and sits between the decode/control stage and the debug/observation logic.

## Interface
- DATA_W, 32: datapath and register width.
- REG_AW, 5: register address width; register count is 2**REG_AW.
- IMM_W, 16: immediate width; sign-extended to DATA_W.
- DM_AW, 8: data-memory word-address width; depth is 2**DM_AW words.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  instruction offered.
- o_ready  out  1  block is idle and accepts the instruction.
- i_op  in  2  operation: 00 R-type, 01 ADDI, 10 LW, 11 SW.
- i_alu_ctrl  in  3  R-type function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 101 NOR.
- i_rs  in  REG_AW  source register 1 / base.
- i_rt  in  REG_AW  source register 2, or destination for ADDI/LW.
- i_rd  in  REG_AW  destination for R-type.
- i_imm  in  IMM_W  immediate.
- o_busy  out  1  instruction in flight.
- o_done  out  1  one-cycle completion pulse.
- o_result  out  DATA_W  ALU result, or load data for LW.
- o_zero  out  1  ALU result equal to zero.
- i_dbg_addr  in  REG_AW  debug register index.
- o_dbg_data  out  DATA_W  combinational register-file read at i_dbg_addr.

## Operation
- States: IDLE → RD → EX → MEM (LW/SW only) → WB → IDLE.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready, latch i_op, i_alu_ctrl, i_rs, i_rt, i_rd and i_imm. Inputs may change freely after this.
  - i_valid outside IDLE is ignored; no queueing.
- RD: read rs and rt; register both operands; sign-extend the immediate.
- EX: compute the ALU result and register it together with o_zero.
  - ADDI, LW and SW force ADD with operand B set to the immediate.
  - SLT returns 1/0 as a signed compare.
  - Arithmetic wraps modulo 2**DATA_W; no overflow flag.
- MEM: word address = ALU result[DM_AW+1:2]; low two bits and upper bits are ignored.
  - LW: register the memory word into the result register.
  - SW: write rt data to memory at the edge leaving MEM.
- WB: o_done=1; o_result holds the final value.
  - Register write happens at the edge leaving WB: R-type to rd, ADDI/LW to rt, SW no write.
  - Writes to register 0 are discarded; register 0 always reads 0.
- Reset:
  - Register file clears to 0; data memory is not reset.
  - FSM → IDLE. Outputs: o_ready=1, o_busy=0, o_done=0, o_result=0, o_zero=0.
  - Reset mid-instruction aborts it with no register or memory write.

## Timing
- Acceptance at edge N.
- R/ADDI: o_done high between edges N+2 and N+3; register write at N+3; o_ready=1 after N+3. Throughput is one instruction per 4 cycles.
- LW/SW: o_done high between N+3 and N+4; write at N+4. Throughput is one per 5 cycles.
- o_busy = not IDLE.
- A debug read of a register written at edge W shows the new value after W.
- An instruction accepted immediately after a write sees the written value; no hazard.

## Structure
- dp_pkg holds:
  - op and ALU-control encodings;
  - the state enum;
  - the SEXT width helper constant.
- Sub-module dp_regfile:
  - two synchronous-input combinational read ports plus a debug read port;
  - one write port;
  - async-reset clear, r0 hardwired to 0.
- ALU and data memory stay inline.

## Test plan
- Reset, then read all registers via the debug port → all 0; o_ready=1, o_done=0.
- ADDI r1=r0+5, then R ADD r2=r1+r1 → o_result=10, o_zero=0. o_done in cycle N+2..N+3. Debug r2=10.
- ADDI r3=r0+0xFFFD (−3); SLT r4=r3,r1 → 1. SUB r5=r1,r1 → 0 with o_zero=1. NOR r6=r0,r0 → 0xFFFFFFFF.
- SW r2 to [r0+8], then LW r7 from [r0+11] (same word) → o_result=10, r7=10. o_done timing N+3..N+4.
- ADDI r0=r0+7 → o_result=7, debug r0 stays 0. i_valid held high through busy → exactly one completion per accepted instruction.
- Assert i_rst_n low during EX of ADDI r8=r0+9 → no write, r8=0. After release, o_ready=1 and the next instruction completes normally.
